ppu_chr_arb: RTL and testbench

- Single-clock arbiter between the PPU pattern fetch port and the CPU $2007 path for the 16-bit CHR SRAM.
- Successor to the combinational "cfg always wins" CHR-RAM mux: cfg accesses are buffered in a FIFO and slotted into PPU idle cycles, so they no longer corrupt PPU fetches.
- A bounded-wait counter guarantees cfg progress.
- Width, FIFO depth and maximum wait are parametrised. Sits inside the PPU VRAM subsystem, in front of the external SRAM pins.

---
 rtl/ppu_chr_arb.sv | 209 ++++++++++++++++++++
 tb/tb_ppu_chr_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_chr_arb.sv
// CHR SRAM arbiter: PPU pattern fetches vs. FIFO-buffered CPU $2007 accesses with bounded cfg wait.
// Define PPU_CHR_ARB_STAT_EN to build the o_stall_cnt pre-emption counter (tied to zero otherwise).
module ppu_chr_arb #(
  parameter int BADDR_W    = 13,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                           i_ppu_clk,
  input  logic                           i_ppu_rst,
  input  logic                           i_cfg_valid,
  output logic                           o_cfg_ready,
  input  logic                           i_cfg_we,
  input  logic [BADDR_W-1:0]             i_cfg_addr,
  input  logic [7:0]                     i_cfg_wdata,
  output logic                           o_cfg_rvalid,
  output logic [7:0]                     o_cfg_rdata,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_level,
  input  logic                           i_pt_req,
  input  logic [BADDR_W-2:0]             i_pt_addr,
  output logic                           o_pt_rvalid,
  output logic [15:0]                    o_pt_rdata,
  output logic                           o_pt_stall,
  output logic [15:0]                    o_stall_cnt,
  output logic [BADDR_W-2:0]             o_sram_addr,
  output logic [15:0]                    o_sram_wdata,
  input  logic [15:0]                    i_sram_rdata,
  output logic                           o_sram_we_n,
  output logic                           o_sram_oe_n,
  output logic                           o_sram_ub_n,
  output logic                           o_sram_lb_n
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int WADDR_W = BADDR_W - 1;
  localparam int ENT_W   = 1 + BADDR_W + 8;
  localparam logic [LVL_W-1:0] DEPTH_L    = LVL_W'(FIFO_DEPTH);
  localparam logic [7:0]       MAX_WAIT_L = 8'(MAX_WAIT);

  typedef enum logic [1:0] {GNT_IDLE, GNT_PPU, GNT_CFG} gnt_e;

  logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         wait_q, wait_d;
  logic [WADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        sram_wdata_q, sram_wdata_d;
  logic               sram_we_n_q, sram_we_n_d, sram_oe_n_q, sram_oe_n_d;
  logic               sram_ub_n_q, sram_ub_n_d, sram_lb_n_q, sram_lb_n_d;
  logic               rd1_ppu_q, rd1_ppu_d, rd1_cfg_q, rd1_cfg_d, rd1_upper_q, rd1_upper_d;
  logic               pt_rvalid_q, pt_rvalid_d, cfg_rvalid_q, cfg_rvalid_d;
  logic [15:0]        pt_rdata_q, pt_rdata_d;
  logic [7:0]         cfg_rdata_q, cfg_rdata_d;

  gnt_e               gnt;
  logic               fifo_nempty, push, pop;
  logic               head_we;
  logic [BADDR_W-1:0] head_addr;
  logic [7:0]         head_wdata;

  // cfg handshake: an entry is taken on any cycle with i_cfg_valid & o_cfg_ready; ready only
  // reflects the registered level, so a same-cycle pop never lets an extra push through.
  assign fifo_nempty = (level_q != '0);
  assign o_cfg_ready = !i_ppu_rst && (level_q < DEPTH_L);
  assign push        = i_cfg_valid && o_cfg_ready;
  assign pop         = (gnt == GNT_CFG);
  assign {head_we, head_addr, head_wdata} = fifo_q[rd_ptr_q];

  always_comb begin
    gnt = GNT_IDLE;
    if (!i_ppu_rst) begin
      if (fifo_nempty && (!i_pt_req || wait_q == MAX_WAIT_L)) gnt = GNT_CFG;
      else if (i_pt_req)                                      gnt = GNT_PPU;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {i_cfg_we, i_cfg_addr, i_cfg_wdata};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Refusal counter: only counts while something is waiting, and pins at MAX_WAIT to force a slot.
  always_comb begin
    wait_d = wait_q;
    if (!fifo_nempty || pop)     wait_d = 8'd0;
    else if (wait_q < MAX_WAIT_L) wait_d = wait_q + 8'd1;
  end

  always_comb begin
    sram_addr_d  = '0;
    sram_wdata_d = 16'h0000;
    sram_we_n_d  = 1'b1;
    sram_oe_n_d  = 1'b0;
    sram_ub_n_d  = 1'b0;
    sram_lb_n_d  = 1'b0;
    unique case (gnt)
      GNT_PPU: sram_addr_d = i_pt_addr;
      GNT_CFG: begin
        sram_addr_d  = {head_addr[BADDR_W-1:4], head_addr[2:0]};
        sram_wdata_d = {head_wdata, head_wdata};
        sram_we_n_d  = !head_we;
        sram_oe_n_d  = head_we;
        sram_ub_n_d  = !head_addr[3];
        sram_lb_n_d  = head_addr[3];
      end
      default: ;
    endcase
  end

  always_comb begin
    rd1_ppu_d    = (gnt == GNT_PPU);
    rd1_cfg_d    = (gnt == GNT_CFG) && !head_we;
    rd1_upper_d  = head_addr[3];
    pt_rvalid_d  = rd1_ppu_q;
    pt_rdata_d   = rd1_ppu_q ? i_sram_rdata : pt_rdata_q;
    cfg_rvalid_d = rd1_cfg_q;
    cfg_rdata_d  = cfg_rdata_q;
    if (rd1_cfg_q) cfg_rdata_d = rd1_upper_q ? i_sram_rdata[15:8] : i_sram_rdata[7:0];
  end

  always_ff @(posedge i_ppu_clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge i_ppu_clk) begin
    if (i_ppu_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      wait_q       <= 8'd0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 16'h0000;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_ub_n_q  <= 1'b1;
      sram_lb_n_q  <= 1'b1;
      rd1_ppu_q    <= 1'b0;
      rd1_cfg_q    <= 1'b0;
      rd1_upper_q  <= 1'b0;
      pt_rvalid_q  <= 1'b0;
      pt_rdata_q   <= 16'h0000;
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= 8'h00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      wait_q       <= wait_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      sram_ub_n_q  <= sram_ub_n_d;
      sram_lb_n_q  <= sram_lb_n_d;
      rd1_ppu_q    <= rd1_ppu_d;
      rd1_cfg_q    <= rd1_cfg_d;
      rd1_upper_q  <= rd1_upper_d;
      pt_rvalid_q  <= pt_rvalid_d;
      pt_rdata_q   <= pt_rdata_d;
      cfg_rvalid_q <= cfg_rvalid_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  // Valid pulses are masked during reset so in-flight reads never surface.
  assign o_pt_stall   = pop && i_pt_req;
  assign o_pt_rvalid  = pt_rvalid_q && !i_ppu_rst;
  assign o_pt_rdata   = pt_rdata_q;
  assign o_cfg_rvalid = cfg_rvalid_q && !i_ppu_rst;
  assign o_cfg_rdata  = cfg_rdata_q;
  assign o_fifo_level = level_q;
  assign o_sram_addr  = sram_addr_q;
  assign o_sram_wdata = sram_wdata_q;
  assign o_sram_we_n  = sram_we_n_q;
  assign o_sram_oe_n  = sram_oe_n_q;
  assign o_sram_ub_n  = sram_ub_n_q;
  assign o_sram_lb_n  = sram_lb_n_q;

`ifdef PPU_CHR_ARB_STAT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_pt_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge i_ppu_clk) begin
    if (i_ppu_rst) stall_cnt_q <= 16'h0000;
    else           stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ppu_chr_arb.sv
// Bench for ppu_chr_arb: vector table, directed multi-cycle sequences, and random traffic
// checked every cycle against a queue/array reference model of the arbitration rules.
module tb_ppu_chr_arb;
  localparam int BADDR_W    = 13;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_WAIT   = 8;

  logic        clk;
  logic        i_ppu_rst;
  logic        i_cfg_valid, o_cfg_ready, i_cfg_we;
  logic [12:0] i_cfg_addr;
  logic [7:0]  i_cfg_wdata;
  logic        o_cfg_rvalid;
  logic [7:0]  o_cfg_rdata;
  logic [2:0]  o_fifo_level;
  logic        i_pt_req;
  logic [11:0] i_pt_addr;
  logic        o_pt_rvalid;
  logic [15:0] o_pt_rdata;
  logic        o_pt_stall;
  logic [15:0] o_stall_cnt;
  logic [11:0] o_sram_addr;
  logic [15:0] o_sram_wdata, i_sram_rdata;
  logic        o_sram_we_n, o_sram_oe_n, o_sram_ub_n, o_sram_lb_n;

  ppu_chr_arb #(.BADDR_W(BADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .i_ppu_clk(clk), .i_ppu_rst(i_ppu_rst),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_we(i_cfg_we),
    .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
    .o_cfg_rvalid(o_cfg_rvalid), .o_cfg_rdata(o_cfg_rdata), .o_fifo_level(o_fifo_level),
    .i_pt_req(i_pt_req), .i_pt_addr(i_pt_addr), .o_pt_rvalid(o_pt_rvalid),
    .o_pt_rdata(o_pt_rdata), .o_pt_stall(o_pt_stall), .o_stall_cnt(o_stall_cnt),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(i_sram_rdata),
    .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_ub_n(o_sram_ub_n), .o_sram_lb_n(o_sram_lb_n)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural SRAM ----------------
  logic [15:0] sram_mem [0:4095];
  logic        mem_clr;
  assign i_sram_rdata = o_sram_oe_n ? 16'h0000 : sram_mem[o_sram_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= (i == 'h155) ? 16'hA55A : 16'h0000;
    end else if (!o_sram_we_n) begin
      if (!o_sram_ub_n) sram_mem[o_sram_addr][15:8] <= o_sram_wdata[15:8];
      if (!o_sram_lb_n) sram_mem[o_sram_addr][7:0]  <= o_sram_wdata[7:0];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed { logic we; logic [12:0] addr; logic [7:0] wdata; } req_t;
  typedef struct { bit chk_wd; logic [11:0] addr; logic [15:0] wdata;
                   logic we_n, oe_n, ub_n, lb_n; } pins_t;
  typedef struct { bit ppu; bit cfg; logic [15:0] data; } rd_t;

  req_t        m_q[$];          // pending cfg requests in push order
  logic [7:0]  exp_q[$];        // expected cfg read bytes, cleared at start
  logic [7:0]  ref_b [0:8191];  // byte image indexed by word*2+lane
  int          m_wait, m_stalls;
  pins_t       m_pins;
  rd_t         m_rd1, m_rd2;

  function automatic int word_of(input logic [12:0] a);
    return (int'(a) / 16) * 8 + (int'(a) % 8);
  endfunction
  function automatic int lane_of(input logic [12:0] a);
    return (int'(a) / 8) % 2;
  endfunction

  // observed outputs of the last step
  logic        obs_stall, obs_ready, obs_cfg_rv, obs_pt_rv;
  logic [2:0]  obs_level;
  logic [7:0]  obs_cfg_rd;
  logic [15:0] obs_pt_rd, obs_wdata;
  logic [11:0] obs_addr;
  logic        obs_we_n, obs_oe_n, obs_ub_n, obs_lb_n;

  // One clock cycle: inputs are already driven; sample at negedge, check model, advance it.
  task automatic step();
    int g;
    bit exp_ready, was_empty;
    req_t h;
    int w, ln;
    @(negedge clk);
    obs_stall = o_pt_stall;   obs_ready = o_cfg_ready;  obs_level = o_fifo_level;
    obs_cfg_rv = o_cfg_rvalid; obs_cfg_rd = o_cfg_rdata;
    obs_pt_rv = o_pt_rvalid;  obs_pt_rd = o_pt_rdata;
    obs_addr = o_sram_addr;   obs_wdata = o_sram_wdata;
    obs_we_n = o_sram_we_n;   obs_oe_n = o_sram_oe_n;
    obs_ub_n = o_sram_ub_n;   obs_lb_n = o_sram_lb_n;

    exp_ready = !i_ppu_rst && (m_q.size() < FIFO_DEPTH);
    g = 0;
    if (!i_ppu_rst) begin
      if (m_q.size() > 0 && (!i_pt_req || m_wait == MAX_WAIT)) g = 2;
      else if (i_pt_req) g = 1;
    end
    check("cfg_ready", obs_ready, exp_ready);
    check("fifo_level", obs_level, m_q.size());
    check("pt_stall", obs_stall, (g == 2) && i_pt_req);
    check("sram_addr", obs_addr, m_pins.addr);
    check("sram_we_n", obs_we_n, m_pins.we_n);
    check("sram_oe_n", obs_oe_n, m_pins.oe_n);
    check("sram_ub_n", obs_ub_n, m_pins.ub_n);
    check("sram_lb_n", obs_lb_n, m_pins.lb_n);
    if (m_pins.chk_wd) check("sram_wdata", obs_wdata, m_pins.wdata);
    check("pt_rvalid", obs_pt_rv, m_rd2.ppu && !i_ppu_rst);
    if (m_rd2.ppu && !i_ppu_rst) check("pt_rdata", obs_pt_rd, m_rd2.data);
    check("cfg_rvalid", obs_cfg_rv, m_rd2.cfg && !i_ppu_rst);
    if (m_rd2.cfg && !i_ppu_rst) check("cfg_rdata", obs_cfg_rd, m_rd2.data[7:0]);
`ifdef PPU_CHR_ARB_STAT_EN
    check("stall_cnt", o_stall_cnt, m_stalls);
`else
    check("stall_cnt_tied", o_stall_cnt, 0);
`endif

    if (i_ppu_rst) begin
      m_q.delete();
      m_wait = 0; m_stalls = 0;
      m_rd1 = '{ppu: 0, cfg: 0, data: 0};
      m_rd2 = '{ppu: 0, cfg: 0, data: 0};
      m_pins = '{chk_wd: 1, addr: 0, wdata: 0, we_n: 1, oe_n: 1, ub_n: 1, lb_n: 1};
    end else begin
      was_empty = (m_q.size() == 0);
      m_rd2 = m_rd1;
      m_rd1 = '{ppu: 0, cfg: 0, data: 0};
      m_pins = '{chk_wd: 0, addr: 0, wdata: 0, we_n: 1, oe_n: 0, ub_n: 0, lb_n: 0};
      if (g == 2) begin
        h = m_q.pop_front();
        w = word_of(h.addr); ln = lane_of(h.addr);
        m_pins.addr = 12'(w);
        m_pins.ub_n = (ln == 1) ? 1'b0 : 1'b1;
        m_pins.lb_n = (ln == 0) ? 1'b0 : 1'b1;
        if (h.we) begin
          ref_b[w*2+ln] = h.wdata;
          m_pins.we_n = 0; m_pins.oe_n = 1;
          m_pins.chk_wd = 1; m_pins.wdata = {h.wdata, h.wdata};
        end else begin
          m_rd1 = '{ppu: 0, cfg: 1, data: {8'h00, ref_b[w*2+ln]}};
        end
      end else if (g == 1) begin
        m_pins.addr = i_pt_addr;
        m_rd1 = '{ppu: 1, cfg: 0, data: {ref_b[int'(i_pt_addr)*2+1], ref_b[int'(i_pt_addr)*2]}};
      end
      if (was_empty || g == 2) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (g == 2 && i_pt_req && m_stalls < 65535) m_stalls++;
      if (i_cfg_valid && exp_ready) m_q.push_back('{we: i_cfg_we, addr: i_cfg_addr, wdata: i_cfg_wdata});
    end
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit is_cfg; bit we; logic [12:0] addr; logic [7:0] wdata;
    logic [11:0] exp_addr; logic exp_we_n, exp_oe_n, exp_ub_n, exp_lb_n;
    logic [15:0] exp_wdata; bit exp_rv; logic [15:0] exp_rd;
  } vec_t;
  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_cfg) begin
      i_cfg_valid = 1; i_cfg_we = v.we; i_cfg_addr = v.addr; i_cfg_wdata = v.wdata;
      step();
      i_cfg_valid = 0;
      step();
      step();
    end else begin
      i_pt_req = 1; i_pt_addr = v.addr[11:0];
      step();
      check($sformatf("vec%0d_no_stall", idx), obs_stall, 0);
      i_pt_req = 0;
      step();
    end
    check($sformatf("vec%0d_addr", idx), obs_addr, v.exp_addr);
    check($sformatf("vec%0d_we_n", idx), obs_we_n, v.exp_we_n);
    check($sformatf("vec%0d_oe_n", idx), obs_oe_n, v.exp_oe_n);
    check($sformatf("vec%0d_ub_n", idx), obs_ub_n, v.exp_ub_n);
    check($sformatf("vec%0d_lb_n", idx), obs_lb_n, v.exp_lb_n);
    if (v.is_cfg && v.we) check($sformatf("vec%0d_wdata", idx), obs_wdata, v.exp_wdata);
    step();
    if (v.is_cfg) begin
      check($sformatf("vec%0d_cfg_rvalid", idx), obs_cfg_rv, v.exp_rv);
      if (v.exp_rv) check($sformatf("vec%0d_cfg_rdata", idx), obs_cfg_rd, v.exp_rd[7:0]);
    end else begin
      check($sformatf("vec%0d_pt_rvalid", idx), obs_pt_rv, v.exp_rv);
      check($sformatf("vec%0d_pt_rdata", idx), obs_pt_rd, v.exp_rd);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int ppu_grants, cnt0;
    bit got, pop_seen, seen;

    vecs[0] = '{0, 0, 13'h0155, 8'h00, 12'h155, 1, 0, 0, 0, 16'h0000, 1, 16'hA55A};
    vecs[1] = '{1, 1, 13'h0018, 8'h3C, 12'h008, 0, 1, 0, 1, 16'h3C3C, 0, 16'h0000};
    vecs[2] = '{1, 1, 13'h1FF7, 8'h11, 12'hFFF, 0, 1, 1, 0, 16'h1111, 0, 16'h0000};
    vecs[3] = '{1, 0, 13'h1FF7, 8'h00, 12'hFFF, 1, 0, 1, 0, 16'h0000, 1, 16'h0011};
    vecs[4] = '{1, 0, 13'h0018, 8'h00, 12'h008, 1, 0, 0, 1, 16'h0000, 1, 16'h003C};
    vecs[5] = '{0, 0, 13'h0008, 8'h00, 12'h008, 1, 0, 0, 0, 16'h0000, 1, 16'h3C00};
    vecs[6] = '{0, 0, 13'h0FFF, 8'h00, 12'hFFF, 1, 0, 0, 0, 16'h0000, 1, 16'h0011};

    i_ppu_rst = 1; i_cfg_valid = 0; i_cfg_we = 0; i_cfg_addr = 0; i_cfg_wdata = 0;
    i_pt_req = 0; i_pt_addr = 0; mem_clr = 1;
    for (int i = 0; i < 8192; i++) ref_b[i] = 8'h00;
    ref_b['h155*2+1] = 8'hA5;
    ref_b['h155*2]   = 8'h5A;
    exp_q.delete();

    // reset block
    @(posedge clk); #1;
    mem_clr = 0;
    m_q.delete(); m_wait = 0; m_stalls = 0;
    m_rd1 = '{ppu: 0, cfg: 0, data: 0};
    m_rd2 = '{ppu: 0, cfg: 0, data: 0};
    m_pins = '{chk_wd: 1, addr: 0, wdata: 0, we_n: 1, oe_n: 1, ub_n: 1, lb_n: 1};
    check("rst_level", o_fifo_level, 0);
    check("rst_ready", o_cfg_ready, 0);
    check("rst_pt_rdata", o_pt_rdata, 0);
    check("rst_cfg_rdata", o_cfg_rdata, 0);
    check("rst_pins", {o_sram_addr, o_sram_wdata, o_sram_we_n, o_sram_oe_n, o_sram_ub_n, o_sram_lb_n},
          {12'h000, 16'h0000, 4'b1111});
    step();
    i_ppu_rst = 0;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // back-to-back write then read of the same byte
    i_cfg_valid = 1; i_cfg_we = 1; i_cfg_addr = 13'h1FF7; i_cfg_wdata = 8'h77;
    step();
    i_cfg_we = 0; i_cfg_wdata = 8'h00;
    step();
    i_cfg_valid = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (obs_cfg_rv) begin
        got = 1;
        check("raw_rdata", obs_cfg_rd, 8'h77);
      end
    end
    check("raw_rvalid_seen", got, 1);

    // starvation bound, twice to show the wait counter cleared
    for (int rep = 0; rep < 2; rep++) begin
      cnt0 = o_stall_cnt;
      i_pt_req = 1; i_pt_addr = 12'($urandom_range(0, 4095));
      i_cfg_valid = 1; i_cfg_we = 1; i_cfg_addr = 13'h0400 + 13'(rep); i_cfg_wdata = 8'h99;
      step();
      i_cfg_valid = 0;
      ppu_grants = 0; got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        step();
        if (obs_stall) got = 1;
        else ppu_grants++;
      end
      check($sformatf("starve%0d_stall_seen", rep), got, 1);
      check($sformatf("starve%0d_ppu_grants", rep), ppu_grants, MAX_WAIT);
`ifdef PPU_CHR_ARB_STAT_EN
      check($sformatf("starve%0d_stall_cnt_delta", rep), int'(o_stall_cnt) - cnt0, 1);
`else
      check($sformatf("starve%0d_stall_cnt_zero", rep), o_stall_cnt, 0);
`endif
    end

    // fill the FIFO while the PPU keeps the SRAM busy
    i_pt_req = 1; i_cfg_valid = 1; i_cfg_we = 0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      i_cfg_addr = 13'($urandom_range(0, 8191));
      step();
      check($sformatf("fill%0d_ready", k), obs_ready, 1);
      check($sformatf("fill%0d_level", k), obs_level, k);
    end
    i_cfg_addr = 13'h0155;
    step();
    check("full_ready", obs_ready, 0);
    check("full_level", obs_level, FIFO_DEPTH);
    got = 0; pop_seen = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (obs_ready) begin
        got = 1;
        check("fifth_after_pop", pop_seen, 1);
      end
      pop_seen |= obs_stall;
    end
    check("fifth_accepted", got, 1);
    i_cfg_valid = 0; i_pt_req = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (obs_level == 0) break;
    end
    check("drain_level", obs_level, 0);
    repeat (3) step();

    // reset with reads queued
    seen = 0;
    i_pt_req = 1; i_cfg_valid = 1; i_cfg_we = 0;
    for (int k = 0; k < 3; k++) begin
      i_cfg_addr = 13'h0018 + 13'(k);
      step();
      seen |= obs_cfg_rv;
    end
    i_cfg_valid = 0;
    step();
    seen |= obs_cfg_rv;
    i_ppu_rst = 1;
    step();
    seen |= obs_cfg_rv;
    step();
    seen |= obs_cfg_rv;
    check("midrst_pins", {obs_addr, obs_wdata, obs_we_n, obs_oe_n, obs_ub_n, obs_lb_n},
          {12'h000, 16'h0000, 4'b1111});
    check("midrst_ready", obs_ready, 0);
    i_ppu_rst = 0; i_pt_req = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      seen |= obs_cfg_rv;
    end
    check("midrst_no_cfg_rvalid", seen, 0);
    check("midrst_level", obs_level, 0);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      i_ppu_rst   = ($urandom_range(0, 99) == 0);
      i_cfg_valid = ($urandom_range(0, 2) == 0);
      i_cfg_we    = 1'($urandom_range(0, 1));
      i_cfg_addr  = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 8191)) : 13'($urandom_range(0, 31));
      i_cfg_wdata = 8'($urandom_range(0, 255));
      i_pt_req    = ($urandom_range(0, 3) != 0);
      i_pt_addr   = 12'($urandom_range(0, 15));
      step();
    end
    i_ppu_rst = 0; i_cfg_valid = 0; i_pt_req = 0;
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
